// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin sensor debounce, queue and paced coin-code transmitter
// Three raw sensors are synchronised and debounced; each detected coin is queued and replayed
// to vending_machine.coin as a single-cycle code followed by an idle gap.
module coin_acceptor #(
   parameter int DEB_CYC = 4,
   parameter int GAP_CYC = 3,
   parameter int DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sense_a,
   input  logic                    sense_b,
   input  logic                    sense_c,
   input  logic                    accept_en,
   output logic [1:0]              coin_out,
   output logic                    reject,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int DCW = $clog2(DEB_CYC);
   localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;

   typedef enum logic {DISARMED, ARMED} db_state_t;
   typedef enum logic [1:0] {IDLE, EMIT, GAP} pace_state_t;

   logic [2:0]     sense_raw;
   logic [2:0]     sync1, sync2;
   logic [1:0]     sync_vld;
   db_state_t      db_state     [3];
   db_state_t      db_state_nxt [3];
   logic [DCW-1:0] db_cnt       [3];
   logic [DCW-1:0] db_cnt_nxt   [3];
   logic [2:0]     det, det_nxt;

   logic           det_any, det_multi, full, push, pop;
   logic [1:0]     det_code;
   logic [1:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [1:0]     code_q;

   pace_state_t    state, state_nxt;
   logic [GCW-1:0] gap_cnt, gap_cnt_nxt;

   assign sense_raw = {sense_c, sense_b, sense_a};

   // Debouncers ignore the sync pipe until it has refilled after reset, so a sensor held
   // high through reset cannot be mistaken for a stable-low run.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         db_state_nxt[i] = db_state[i];
         db_cnt_nxt[i]   = db_cnt[i];
      end
      det_nxt = '0;
      if (sync_vld[1]) begin
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != (db_state[i] == ARMED)) begin
               db_cnt_nxt[i] = '0;
            end else if (db_cnt[i] == DCW'(DEB_CYC - 1)) begin
               db_cnt_nxt[i]   = '0;
               det_nxt[i]      = (db_state[i] == ARMED);
               db_state_nxt[i] = (db_state[i] == ARMED) ? DISARMED : ARMED;
            end else begin
               db_cnt_nxt[i] = db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign det_any   = (det != 3'd0);
   assign det_multi = ((det & (det - 3'd1)) != 3'd0);
   assign det_code  = {det[2] | det[1], det[2] | det[0]};
   assign full      = (fifo_count == CW'(DEPTH));
   assign push      = det_any && !det_multi && accept_en && !full;
   assign busy      = (fifo_count != '0) || (state != IDLE);

   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop       = 1'b1;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
         end
         GAP: begin
            if (gap_cnt == GCW'(GAP_CYC - 1)) begin
               state_nxt = IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= det_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= '0;
         sync2      <= '0;
         sync_vld   <= '0;
         for (int i = 0; i < 3; i++) begin
            db_state[i] <= DISARMED;
            db_cnt[i]   <= '0;
         end
         det        <= '0;
         reject     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         state      <= IDLE;
         gap_cnt    <= '0;
         code_q     <= 2'b00;
         coin_out   <= 2'b00;
      end else begin
         sync1    <= sense_raw;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
         for (int i = 0; i < 3; i++) begin
            db_state[i] <= db_state_nxt[i];
            db_cnt[i]   <= db_cnt_nxt[i];
         end
         det    <= det_nxt;
         reject <= det_any && !push;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            code_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         state    <= state_nxt;
         gap_cnt  <= gap_cnt_nxt;
         // One cycle behind the EMIT state, so the code lives exactly one cycle.
         coin_out <= (state == EMIT) ? code_q : 2'b00;
      end
   end

endmodule
